// File: rtl/instr_queue.sv
// 16-entry circular instruction queue: accepts 4-wide fetch groups, presents the two oldest entries to decode.
// Optional full-stall performance counter enabled by defining IQ_PERF_EN.
module instr_queue (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0][31:0]  PC,
    input  logic [3:0][31:0]  instr,
    input  logic              flush,
    input  logic [1:0]        issue_num,
    output logic              queue_full,
    output logic [1:0]        out_valid,
    output logic [1:0][31:0]  out_PC,
    output logic [1:0][31:0]  out_instr,
    output logic [31:0]       full_stall_cnt
);

    logic [31:0] pc_mem_q    [16];
    logic [31:0] instr_mem_q [16];

    logic [3:0] head_q, head_d;
    logic [3:0] tail_q, tail_d;
    logic [4:0] count_q, count_d;

    logic       group_offered;
    logic       wr_en;
    logic [4:0] issue_req;
    logic [4:0] issued;

    assign group_offered = (PC[0] != 32'h0);

    always_comb begin
        queue_full = (count_q > 5'd12);
        wr_en      = group_offered && !queue_full && !flush;
        issue_req  = (issue_num == 2'd3) ? 5'd2 : {3'b000, issue_num};
        // Decode may ask for more than is held; never consume past the last entry.
        issued     = (issue_req < count_q) ? issue_req : count_q;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 4'd0;
            tail_d  = 4'd0;
            count_d = 5'd0;
        end else begin
            head_d  = head_q + issued[3:0];
            tail_d  = wr_en ? tail_q + 4'd4 : tail_q;
            count_d = count_q + (wr_en ? 5'd4 : 5'd0) - issued;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 4'd0;
            tail_q  <= 4'd0;
            count_q <= 5'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                pc_mem_q[tail_q + 4'(i)]    <= PC[i];
                instr_mem_q[tail_q + 4'(i)] <= instr[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            always_comb begin
                out_valid[gi] = !reset && (count_q > 5'(gi));
                out_PC[gi]    = out_valid[gi] ? pc_mem_q[head_q + 4'(gi)]    : 32'h0;
                out_instr[gi] = out_valid[gi] ? instr_mem_q[head_q + 4'(gi)] : 32'h0;
            end
        end
    endgenerate

`ifdef IQ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + ((queue_full && group_offered) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign full_stall_cnt = stall_cnt_q;
`else
    assign full_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Randomized scoreboard bench for instr_queue: a FIFO reference model predicts the
// post-edge outputs, and a monitor compares them one edge later.
module tb_instr_queue;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0][31:0]  PC;
    logic [3:0][31:0]  instr;
    logic              flush;
    logic [1:0]        issue_num;
    logic              queue_full;
    logic [1:0]        out_valid;
    logic [1:0][31:0]  out_PC;
    logic [1:0][31:0]  out_instr;
    logic [31:0]       full_stall_cnt;

    always #5 clk = ~clk;

    instr_queue dut (
        .clk            (clk),
        .reset          (reset),
        .PC             (PC),
        .instr          (instr),
        .flush          (flush),
        .issue_num      (issue_num),
        .queue_full     (queue_full),
        .out_valid      (out_valid),
        .out_PC         (out_PC),
        .out_instr      (out_instr),
        .full_stall_cnt (full_stall_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        full;
        logic [1:0]  valid;
        logic [31:0] pc0, pc1, in0, in1, cnt;
    } exp_t;

    ent_t        mq[$];
    exp_t        exp_q[$];
    logic [31:0] m_cnt = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // Reference: the queue is a plain FIFO of entries; full means more than 12 held.
    task automatic model_step();
        bit   full;
        int   want, n;
        exp_t e;
        full = (mq.size() > 12);
        if (reset) begin
            mq.delete();
            m_cnt = 32'd0;
        end else begin
            if (full && PC[0] != 32'h0) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                mq.delete();
            end else begin
                want = (issue_num == 2'd3) ? 2 : int'(issue_num);
                n = (want < mq.size()) ? want : mq.size();
                repeat (n) void'(mq.pop_front());
                if (PC[0] != 32'h0 && !full)
                    for (int i = 0; i < 4; i++) mq.push_back('{pc: PC[i], ins: instr[i]});
            end
        end
        e.full  = (mq.size() > 12);
        e.valid = {mq.size() >= 2, mq.size() >= 1};
        e.pc0   = (mq.size() >= 1) ? mq[0].pc  : 32'h0;
        e.in0   = (mq.size() >= 1) ? mq[0].ins : 32'h0;
        e.pc1   = (mq.size() >= 2) ? mq[1].pc  : 32'h0;
        e.in1   = (mq.size() >= 2) ? mq[1].ins : 32'h0;
`ifdef IQ_PERF_EN
        e.cnt   = m_cnt;
`else
        e.cnt   = 32'd0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, input bit fl, input logic [31:0] base,
                         input logic [1:0] iss, input bit holes);
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        issue_num = iss;
        for (int i = 0; i < 4; i++) begin
            PC[i] = (base == 32'h0) ? 32'h0 : base + 32'(4 * i);
            if (holes && i > 0 && $urandom_range(0, 7) == 0) PC[i] = 32'h0;
            instr[i] = $urandom;
        end
        model_step();
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("queue_full", 32'(queue_full), 32'(e.full));
                check("out_valid",  32'(out_valid),  32'(e.valid));
                check("out_PC0",    out_PC[0],       e.pc0);
                check("out_PC1",    out_PC[1],       e.pc1);
                check("out_instr0", out_instr[0],    e.in0);
                check("out_instr1", out_instr[1],    e.in1);
                check("stall_cnt",  full_stall_cnt,  e.cnt);
                $display("cycle %0d: valid=%b full=%b pc0=%h pc1=%h cnt=%0d", cyc,
                         out_valid, queue_full, out_PC[0], out_PC[1], full_stall_cnt);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] base;
        logic [1:0]  iss;
        int          phase;
        reset = 1'b1; flush = 1'b0; issue_num = 2'd0; PC = '0; instr = '0;

        drive(1, 0, 32'h0, 2'd0, 0);
        drive(1, 0, 32'h0, 2'd0, 0);
        // Basic write, fill to full, blocked 5th group (counter advances).
        drive(0, 0, 32'hbfc00000, 2'd0, 0);
        drive(0, 0, 32'hbfc00010, 2'd0, 0);
        drive(0, 0, 32'hbfc00020, 2'd0, 0);
        drive(0, 0, 32'hbfc00030, 2'd0, 0);
        drive(0, 0, 32'hbfc00040, 2'd0, 0);
        drive(0, 0, 32'hbfc00050, 2'd0, 0);
        drive(0, 0, 32'hbfc00060, 2'd0, 0);
        // Write blocked while full but issue proceeds, then drain with over-issue.
        drive(0, 0, 32'hbfc00070, 2'd2, 0);
        drive(0, 0, 32'hbfc00080, 2'd2, 0);
        drive(0, 0, 32'hbfc00090, 2'd0, 0);
        // Flush with a write and issue in the same cycle.
        drive(0, 1, 32'hbfc000a0, 2'd2, 0);
        // Reach count 13, then write + issue 2 -> blocked, count 11, then write -> 15.
        drive(0, 0, 32'h80000000, 2'd0, 0);
        drive(0, 0, 32'h80000010, 2'd0, 0);
        drive(0, 0, 32'h80000020, 2'd0, 0);
        drive(0, 0, 32'h80000030, 2'd1, 0);
        drive(0, 0, 32'h0,        2'd2, 0);
        drive(0, 0, 32'h80000040, 2'd2, 0);
        drive(0, 0, 32'h80000050, 2'd0, 0);
        // Drain across the 15->0 index wrap, ending with the count=1 clamp.
        drive(0, 0, 32'h0, 2'd2, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 32'h0, 2'd2, 0);
        drive(0, 0, 32'h0, 2'd3, 0);
        drive(0, 0, 32'h90000000, 2'd0, 0);
        drive(0, 0, 32'h0, 2'd3, 0);
        drive(0, 0, 32'h0, 2'd1, 0);
        drive(0, 0, 32'h0, 2'd2, 0);
        drive(0, 0, 32'h0, 2'd2, 0);

        for (int c = 0; c < 3000; c++) begin
            phase = (c / 48) % 3;
            base  = ($urandom_range(0, 3) != 0) ? {$urandom_range(1, 32'h3fffffff), 2'b00} : 32'h0;
            case (phase)
                0:       iss = ($urandom_range(0, 4) == 0) ? 2'd1 : 2'd0;
                1:       iss = 2'($urandom_range(1, 3));
                default: iss = 2'($urandom_range(0, 3));
            endcase
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0, base, iss, 1);
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port PC, input, addr_t[3:0]: fetch-group PCs, lane 0 oldest; PC[0]==32'h0 means no group offered.
REQ-004 SHALL have port instr, input, instr_t[3:0]: fetch-group instructions, lane-aligned with PC.
REQ-005 SHALL have port flush, input, 1 bit: discard all queued entries.
REQ-006 SHALL have port issue_num, input, 2 bits: entries consumed by decode this cycle; legal values are 0, 1 and 2.
REQ-007 SHALL have port queue_full, output, 1 bit: no room for a 4-entry group.
REQ-008 SHALL have port out_valid, output, 2 bits: per-slot valid, slot 0 oldest.
REQ-009 SHALL have port out_PC, output, addr_t[1:0]: PCs of the two oldest entries.
REQ-010 SHALL have port out_instr, output, instr_t[1:0]: instructions of the two oldest entries.
REQ-011 SHALL have port full_stall_cnt, output, 32 bits: performance counter (see Configuration).

Function
REQ-012 SHALL be a circular buffer of 16 entries; each entry holds {PC, instr}.
REQ-013 SHALL use a 4-bit head pointer, a 4-bit tail pointer and a 5-bit count (0..16); both pointers wrap modulo 16.
REQ-014 SHALL drive queue_full combinationally from the registered count: queue_full=1 iff count>12.
REQ-015 SHALL accept a write when PC[0]!=0, queue_full==0 and flush==0.
REQ-016 SHALL, on a write, store lanes 0..3 at tail..tail+3 (mod 16) and advance tail by 4.
REQ-017 SHALL store a group as a whole, including lanes whose PC is 0; the whole group is never partially accepted.
REQ-018 SHALL drive out_valid[0]=(count>=1) and out_valid[1]=(count>=2), combinationally from registered state.
REQ-019 SHALL drive out_PC[i]/out_instr[i] from entry head+i (mod 16) when out_valid[i]=1, and 0 otherwise.
REQ-020 SHALL compute the number of entries issued as min(issue_num, count), with issue_num==3 treated as 2; head advances by that number.
REQ-021 SHALL apply a write and an issue in the same cycle together: count_next = count + 4*write - issued.
REQ-022 SHALL give read-after-write latency of 1 cycle: a group written in cycle N is visible at the outputs in cycle N+1.
REQ-023 SHALL, when empty, keep out_valid=0 even while a write is in progress; there is no same-cycle bypass.
REQ-024 SHALL give flush priority over write and issue: head, tail and count become 0 next cycle, and an incoming group is dropped.
REQ-025 SHALL hold the queue stable during queue_full except for issues; it never overflows and never underflows.

Reset
REQ-026 SHALL, on reset, set head=0, tail=0 and count=0.
REQ-027 SHALL, under reset, give outputs queue_full=0, out_valid=0, out_PC=0, out_instr=0 and full_stall_cnt=0.
REQ-028 SHALL give reset priority over flush, write and issue, and SHALL discard any in-flight operation when reset asserts mid-operation.
REQ-029 SHALL not reset the entry storage contents.

Configuration
REQ-030 SHALL, with macro IQ_PERF_EN defined, increment full_stall_cnt by 1 each cycle that queue_full=1 and PC[0]!=0.
REQ-031 SHALL, with IQ_PERF_EN defined, let full_stall_cnt wrap from 32'hFFFFFFFF to 0, and SHALL not clear the counter on flush.
REQ-032 SHALL, without IQ_PERF_EN defined, tie full_stall_cnt to 0 and instantiate no counter logic.

Verification
REQ-033 SHALL cover the basic write: write PC=bfc00000..bfc0000c with issue_num=0 -> next cycle count=4, out_valid=2'b11, out_PC[0]=bfc00000, out_PC[1]=bfc00004.
REQ-034 SHALL cover fill to full: 4 writes with issue_num=0 -> count=16, queue_full=1; a 5th group offered is not stored and tail is unchanged.
REQ-035 SHALL cover simultaneous write and issue: count=13, write plus issue_num=2 -> write is blocked (full), count=11; next cycle queue_full=0 and the next write gives count=15 if issue_num=0.
REQ-036 SHALL cover wrap-around: head=14, tail=14; write one group and issue 2 per cycle -> out_PC order is preserved across index 15->0.
REQ-037 SHALL cover flush priority: flush with a write and issue_num=2 in the same cycle -> next cycle count=0, out_valid=0, and the group is dropped.
REQ-038 SHALL cover the over-issue clamp and the counter: count=1 with issue_num=2 -> count=0, head+1; with IQ_PERF_EN, 3 blocked cycles give full_stall_cnt=3.
